// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: sequencer states, opcode
// constants and the saturating issue-counter helper.
package lcd_pkg;

   localparam int CMD_W = 4;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_FETCH      = 4'd1,
      ST_LOAD       = 4'd2,
      ST_WAIT_READY = 4'd3,
      ST_ISSUE      = 4'd4,
      ST_GAP        = 4'd5,
      ST_WAIT_DONE  = 4'd6,
      ST_FINISH     = 4'd7,
      ST_ERROR      = 4'd8
   } seq_state_e;

   localparam logic [CMD_W-1:0] CMD_WRITE       = 4'h0;
   localparam logic [CMD_W-1:0] CMD_SHIFT_UP    = 4'h1;
   localparam logic [CMD_W-1:0] CMD_SHIFT_DOWN  = 4'h2;
   localparam logic [CMD_W-1:0] CMD_SHIFT_LEFT  = 4'h3;
   localparam logic [CMD_W-1:0] CMD_SHIFT_RIGHT = 4'h4;
   localparam logic [CMD_W-1:0] CMD_MAX         = 4'h5;
   localparam logic [CMD_W-1:0] CMD_MIN         = 4'h6;
   localparam logic [CMD_W-1:0] CMD_AVERAGE     = 4'h7;
   localparam logic [CMD_W-1:0] CMD_ROT_CCW     = 4'h8;
   localparam logic [CMD_W-1:0] CMD_ROT_CW      = 4'h9;
   localparam logic [CMD_W-1:0] CMD_MIRROR_X    = 4'hA;
   localparam logic [CMD_W-1:0] CMD_MIRROR_Y    = 4'hB;

   // Counter that sticks at its maximum instead of wrapping.
   function automatic logic [6:0] sat_inc7(input logic [6:0] v);
      if (v == 7'h7F) begin
         return v;
      end else begin
         return v + 7'd1;
      end
   endfunction

endpackage

// File: rtl/lcd_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// expiry once the count reaches TIMEOUT.
module lcd_watchdog #(
   parameter int TO_W    = 12,
   parameter int TIMEOUT = 4095
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

   logic [TO_W-1:0] count_r;

   // Count register; holds at LIMIT so it can never wrap back to zero.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != LIMIT)) begin
         count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = (count_r == LIMIT);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Host-side command issuer: fetches opcodes from a command ROM and hands
// them to LCD_CTRL over the cmd/cmd_valid/busy handshake.
module lcd_cmd_sequencer
   import lcd_pkg::*;
#(
   parameter int N_CMD   = 46,
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 4095,
   parameter int TO_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              cmd_rom_rd,
   output logic [ADDR_W-1:0] cmd_rom_a,
   input  logic [CMD_W-1:0]  cmd_rom_q,
   output logic [CMD_W-1:0]  cmd,
   output logic              cmd_valid,
   input  logic              busy,
   input  logic              done,
   output logic              seq_done,
   output logic              seq_err,
   output logic [6:0]        issued_cnt
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_CMD - 1);

   seq_state_e        state_r, state_s;
   logic [ADDR_W-1:0] ptr_r, ptr_s;
   logic [ADDR_W-1:0] rom_a_r;
   logic [CMD_W-1:0]  cmd_r;
   logic [6:0]        issued_r;
   logic              rom_rd_r, cmd_valid_r, seq_done_r, seq_err_r, done_seen_r;
   logic              accept_s, wd_clear_s, wd_enable_s, wd_expire_s;

   assign accept_s    = (state_r == ST_IDLE) && start;
   assign wd_clear_s  = (state_s != state_r);
   assign wd_enable_s = (state_r == ST_WAIT_READY) || (state_r == ST_WAIT_DONE);

   lcd_watchdog #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear_s),
      .enable (wd_enable_s),
      .expire (wd_expire_s)
   );

   // Next-state and pointer logic. LOAD skips WAIT_READY when the controller
   // is already idle, giving the 4-cycle minimum issue interval.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_FETCH;
               ptr_s   = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FETCH: state_s = ST_LOAD;
         ST_LOAD: begin
            if (busy) begin
               state_s = ST_WAIT_READY;
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_WAIT_READY: begin
            if (!busy) begin
               state_s = ST_ISSUE;
            end else if (wd_expire_s) begin
               state_s = ST_ERROR;
            end else begin
               state_s = ST_WAIT_READY;
            end
         end
         ST_ISSUE: state_s = ST_GAP;
         ST_GAP: begin
            if ((cmd_r == CMD_WRITE) || (ptr_r == LAST_PTR)) begin
               state_s = ST_WAIT_DONE;
            end else begin
               state_s = ST_FETCH;
               ptr_s   = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
         end
         ST_WAIT_DONE: begin
            if (done || done_seen_r) begin
               state_s = ST_FINISH;
            end else if (wd_expire_s) begin
               state_s = ST_ERROR;
            end else begin
               state_s = ST_WAIT_DONE;
            end
         end
         ST_FINISH: state_s = ST_IDLE;
         ST_ERROR:  state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State, pointer and registered outputs, all decoded from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= ST_IDLE;
         ptr_r       <= '0;
         rom_rd_r    <= 1'b0;
         rom_a_r     <= '0;
         cmd_r       <= '0;
         cmd_valid_r <= 1'b0;
         seq_done_r  <= 1'b0;
         seq_err_r   <= 1'b0;
         issued_r    <= 7'd0;
         done_seen_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         rom_rd_r    <= (state_s == ST_FETCH);
         rom_a_r     <= (state_s == ST_FETCH) ? ptr_s : rom_a_r;
         cmd_r       <= (state_r == ST_LOAD) ? cmd_rom_q : cmd_r;
         cmd_valid_r <= (state_s == ST_ISSUE);
         if (accept_s) begin
            seq_done_r  <= 1'b0;
            seq_err_r   <= 1'b0;
            issued_r    <= 7'd0;
            done_seen_r <= 1'b0;
         end else begin
            seq_done_r  <= seq_done_r | (state_s == ST_FINISH);
            seq_err_r   <= seq_err_r | (state_s == ST_ERROR);
            issued_r    <= (state_s == ST_ISSUE) ? sat_inc7(issued_r) : issued_r;
            // An early done (e.g. in GAP) must survive until WAIT_DONE.
            done_seen_r <= done_seen_r | (done && (state_r != ST_IDLE));
         end
      end
   end

   assign cmd_rom_rd = rom_rd_r;
   assign cmd_rom_a  = rom_a_r;
   assign cmd        = cmd_r;
   assign cmd_valid  = cmd_valid_r;
   assign seq_done   = seq_done_r;
   assign seq_err    = seq_err_r;
   assign issued_cnt = issued_r;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: table-driven scenarios, a
// mid-sequence reset, and randomized ROM/busy runs against a list model.
module tb_lcd_cmd_sequencer;

   localparam int N_CMD   = 46;
   localparam int ADDR_W  = 6;
   localparam int TIMEOUT = 15;
   localparam int TO_W    = 4;

   logic              clk = 1'b0;
   logic              reset, start, busy, done;
   logic              cmd_rom_rd, cmd_valid, seq_done, seq_err;
   logic [ADDR_W-1:0] cmd_rom_a;
   logic [3:0]        cmd_rom_q, cmd;
   logic [6:0]        issued_cnt;

   lcd_cmd_sequencer #(
      .N_CMD(N_CMD), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .cmd_rom_rd(cmd_rom_rd), .cmd_rom_a(cmd_rom_a), .cmd_rom_q(cmd_rom_q),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
      .seq_done(seq_done), .seq_err(seq_err), .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rom4;      // entries 0..3 (kind 0), nibble 0 = entry 0
      int          kind;      // 0: rom4 then 1s, 1: 46-entry list ending in 0, 2: no zero
      int          bmode;     // 0: idle, 1: 10 cycles after each issue, 2: stuck, 3: random
      int          ddly;      // cycles from last issue to done pulse
      int          exp_cnt;
      int          exp_done;
      int          exp_err;
      int          exp_max;
   } vec_t;

   vec_t vecs[7];

   int   vectors = 0, errors = 0, cyc = 0;
   logic [3:0] rom[64];
   logic [3:0] exp_q[$], obs_q[$];
   int   issue_t[$];
   int   rd_idx, max_a, viol, busy_cnt, last_issue_t, done_t;
   int   bmode, ddly, done_en, done_fired, noise_en;
   logic rom_pend;
   logic [ADDR_W-1:0] rom_pend_a;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: observe DUT just after the edge, then drive the next inputs.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      cmd_rom_q  = rom_pend ? rom[rom_pend_a] : ~cmd_rom_q;
      rom_pend   = cmd_rom_rd;
      rom_pend_a = cmd_rom_a;
      if (cmd_rom_rd) begin
         chk("rom_addr_order", int'(cmd_rom_a), rd_idx);
         rd_idx++;
         if (int'(cmd_rom_a) > max_a) max_a = int'(cmd_rom_a);
      end
      if (cmd_valid) begin
         obs_q.push_back(cmd);
         issue_t.push_back(cyc);
         last_issue_t = cyc;
         if (busy && bmode == 1) viol++;
      end
      case (bmode)
         0: busy = 1'b0;
         1: begin
            busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (cmd_valid) busy_cnt = 10;
         end
         2: busy = 1'b1;
         default: busy = ($urandom_range(0, 3) == 0);
      endcase
      done = 1'b0;
      if (done_en != 0 && done_fired == 0 && exp_q.size() > 0 &&
          obs_q.size() == exp_q.size() && cyc == last_issue_t + ddly) begin
         done       = 1'b1;
         done_fired = 1;
         done_t     = cyc;
      end
      start = (noise_en != 0) && !(seq_done || seq_err) && ($urandom_range(0, 7) == 0);
   endtask

   task automatic load_rom(input logic [15:0] r4, input int kind);
      for (int i = 0; i < 64; i++) begin
         case (kind)
            0:       rom[i] = (i < 4) ? r4[4*i +: 4] : 4'h1;
            1:       rom[i] = (i < 45) ? 4'((i % 15) + 1) : 4'h0;
            default: rom[i] = 4'((i % 15) + 1);
         endcase
      end
   endtask

   // Expected issue list: ROM in order, through the first write opcode,
   // never beyond N_CMD entries.
   task automatic build_model(input int bm);
      exp_q.delete();
      if (bm != 2) begin
         for (int i = 0; i < N_CMD; i++) begin
            exp_q.push_back(rom[i]);
            if (rom[i] == 4'h0) break;
         end
      end
   endtask

   task automatic run_case(input int bm, input int dd, input int nz, input int exp_cnt,
                           input int exp_done, input int exp_err, input int exp_max,
                           input string tag);
      int start_t, end_t, fin, n;
      build_model(bm);
      obs_q.delete();
      issue_t.delete();
      rd_idx = 0; max_a = 0; viol = 0; busy_cnt = 0; done_fired = 0;
      done_t = -100; last_issue_t = -100; end_t = -1; fin = 0;
      bmode = bm; ddly = dd; done_en = 1; noise_en = nz;
      busy  = (bm == 2);
      start = 1'b1;
      start_t = cyc;
      tick();
      chk({tag, ":seq_done_cleared"}, int'(seq_done), 0);
      chk({tag, ":seq_err_cleared"}, int'(seq_err), 0);
      chk({tag, ":issued_cnt_cleared"}, int'(issued_cnt), 0);
      for (int i = 0; i < 3000 && fin == 0; i++) begin
         tick();
         if (seq_done || seq_err) begin
            fin   = 1;
            end_t = cyc;
         end
      end
      chk({tag, ":terminated"}, fin, 1);
      chk({tag, ":seq_done"}, int'(seq_done), exp_done);
      chk({tag, ":seq_err"}, int'(seq_err), exp_err);
      chk({tag, ":issued_cnt"}, int'(issued_cnt), exp_cnt);
      chk({tag, ":issue_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, ":issue_cmd"}, int'(obs_q[i]), int'(exp_q[i]));
      chk({tag, ":max_rom_addr"}, max_a, exp_max);
      if (bm == 1) chk({tag, ":issue_while_busy"}, viol, 0);
      if (bm == 0 && issue_t.size() > 0) begin
         chk({tag, ":first_issue_latency"}, issue_t[0] - start_t, 3);
         for (int i = 1; i < issue_t.size(); i++)
            chk({tag, ":issue_interval"}, issue_t[i] - issue_t[i-1], 4);
      end
      if (exp_done != 0) chk({tag, ":done_to_seq_done"}, end_t - done_t, (dd == 1) ? 2 : 1);
      if (exp_err != 0) chk({tag, ":timeout_cycles"}, end_t - start_t, 3 + TIMEOUT + 1);
      noise_en = 0; done_en = 0; bmode = 0;
      repeat (3) tick();
      chk({tag, ":seq_done_sticky"}, int'(seq_done), exp_done);
      chk({tag, ":seq_err_sticky"}, int'(seq_err), exp_err);
      chk({tag, ":idle_cmd_valid"}, int'(cmd_valid), 0);
   endtask

   initial begin
      int seen, cnt;
      vecs[0] = '{16'h0043, 0, 0, 3, 3,  1, 0, 2};   // {3,4,0}, busy low
      vecs[1] = '{16'h7705, 0, 0, 2, 2,  1, 0, 1};   // stop after write, addr 2 unread
      vecs[2] = '{16'h00FC, 0, 1, 4, 3,  1, 0, 2};   // C/F passed through verbatim
      vecs[3] = '{16'h0001, 0, 2, 3, 0,  0, 1, 0};   // busy stuck: watchdog
      vecs[4] = '{16'h0000, 1, 1, 2, 46, 1, 0, 45};  // 46-entry list, busy model
      vecs[5] = '{16'h0000, 2, 0, 6, 46, 1, 0, 45};  // no write opcode: pointer cap
      vecs[6] = '{16'h0043, 0, 0, 1, 3,  1, 0, 2};   // done pulse lands in GAP

      reset = 1'b0; start = 1'b0; busy = 1'b0; done = 1'b0; cmd_rom_q = 4'h0;
      rom_pend = 1'b0; rom_pend_a = '0; bmode = 0; done_en = 0; noise_en = 0;
      rd_idx = 0; max_a = 0;
      load_rom(16'h0043, 0);
      repeat (3) tick();
      chk("reset:cmd_valid", int'(cmd_valid), 0);
      chk("reset:cmd", int'(cmd), 0);
      chk("reset:cmd_rom_rd", int'(cmd_rom_rd), 0);
      chk("reset:cmd_rom_a", int'(cmd_rom_a), 0);
      chk("reset:seq_done", int'(seq_done), 0);
      chk("reset:seq_err", int'(seq_err), 0);
      chk("reset:issued_cnt", int'(issued_cnt), 0);
      reset = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         load_rom(vecs[v].rom4, vecs[v].kind);
         run_case(vecs[v].bmode, vecs[v].ddly, 0, vecs[v].exp_cnt, vecs[v].exp_done,
                  vecs[v].exp_err, vecs[v].exp_max, $sformatf("vec%0d", v));
      end

      // Reset applied in the ISSUE cycle, then a clean restart from address 0.
      load_rom(16'h0043, 0);
      exp_q.delete(); obs_q.delete(); issue_t.delete();
      rd_idx = 0; max_a = 0; bmode = 0; done_en = 0; noise_en = 0;
      start = 1'b1;
      tick();
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         tick();
         if (cmd_valid) seen = 1;
      end
      chk("midreset:reached_issue", seen, 1);
      reset = 1'b0;
      tick();
      chk("midreset:cmd_valid", int'(cmd_valid), 0);
      chk("midreset:issued_cnt", int'(issued_cnt), 0);
      chk("midreset:cmd", int'(cmd), 0);
      chk("midreset:cmd_rom_rd", int'(cmd_rom_rd), 0);
      chk("midreset:cmd_rom_a", int'(cmd_rom_a), 0);
      chk("midreset:seq_done", int'(seq_done), 0);
      chk("midreset:seq_err", int'(seq_err), 0);
      reset = 1'b1;
      tick();
      run_case(0, 3, 0, 3, 1, 0, 2, "restart");

      // Random ROM contents, random busy and stray start pulses mid-sequence.
      for (int r = 0; r < 16; r++) begin
         int bm, nozero;
         nozero = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < 64; i++)
            rom[i] = (nozero == 0 && $urandom_range(0, 9) == 0) ? 4'h0
                                                                : 4'($urandom_range(1, 15));
         build_model(0);
         cnt = exp_q.size();
         bm  = ($urandom_range(0, 1) == 0) ? 1 : 3;
         run_case(bm, $urandom_range(1, 6), (bm == 3) ? 1 : 0, cnt, 1, 0, cnt - 1,
                  $sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
